// File: rtl/hazard_sequencer.sv
// Hazard and flush sequencer for the 5-stage RISC-V pipeline: tracks in-flight destination
// registers, stalls PC and IF/ID on RAW hazards, squashes wrong-path work after taken branches.
module hazard_sequencer #(
  parameter bit FORWARDING   = 1'b1,
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr_id,
  input  logic               instr_valid,
  input  logic               branch_taken,
  output logic               nop_o,
  output logic               pc_write_en,
  output logic               ifid_write_en,
  output logic               stall_o,
  output logic               flush_o,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  sb_entry_t r_ex, r_mem, r_wb;
  logic [2:0] r_flush_cnt;
  logic [COUNT_W-1:0] r_stall_count, r_flush_count;

  logic [6:0] w_opcode;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_load;
  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic w_hit_rs1, w_hit_rs2;
  logic w_hazard, w_flush, w_stall, w_issue;
  sb_entry_t w_id_entry;
  logic w_unused;

  assign w_opcode = instr_id[6:0];
  assign w_rd     = instr_id[11:7];
  assign w_rs1    = instr_id[19:15];
  assign w_rs2    = instr_id[24:20];

  assign w_uses_rs1  = (w_opcode != OP_LUI) && (w_opcode != OP_AUIPC) && (w_opcode != OP_JAL);
  assign w_uses_rs2  = (w_opcode == OP_OP) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);
  assign w_writes_rd = (w_opcode != OP_STORE) && (w_opcode != OP_BRANCH) && (w_rd != 5'd0);
  assign w_is_load   = (w_opcode == OP_LOAD);

  assign w_ex_m1  = r_ex.valid  && (r_ex.rd  == w_rs1);
  assign w_ex_m2  = r_ex.valid  && (r_ex.rd  == w_rs2);
  assign w_mem_m1 = r_mem.valid && (r_mem.rd == w_rs1);
  assign w_mem_m2 = r_mem.valid && (r_mem.rd == w_rs2);

  // With forwarding only a load in EX is too late to forward; without it EX and MEM both block.
  assign w_hit_rs1 = (w_rs1 != 5'd0) &&
                     (FORWARDING ? (w_ex_m1 && r_ex.is_load) : (w_ex_m1 || w_mem_m1));
  assign w_hit_rs2 = (w_rs2 != 5'd0) &&
                     (FORWARDING ? (w_ex_m2 && r_ex.is_load) : (w_ex_m2 || w_mem_m2));

  assign w_hazard = instr_valid && ((w_uses_rs1 && w_hit_rs1) || (w_uses_rs2 && w_hit_rs2));
  assign w_flush  = branch_taken || (r_flush_cnt != 3'd0);
  assign w_stall  = w_hazard && !w_flush;
  assign w_issue  = instr_valid && !(w_stall || w_flush);

  assign w_id_entry = '{valid: w_issue && w_writes_rd, rd: w_rd, is_load: w_is_load};

  // NOTE: outputs are gated by rst_n directly so the pipeline is frozen for the whole reset
  // assertion, not just from the next clock edge.
  assign stall_o       = rst_n && w_stall;
  assign flush_o       = rst_n && w_flush;
  assign nop_o         = !rst_n || w_stall || w_flush;
  assign pc_write_en   = rst_n && !w_stall;
  assign ifid_write_en = rst_n && !w_stall;
  assign stall_count   = r_stall_count;
  assign flush_count   = r_flush_count;

  // WB is tracked for visibility only: the register file writes before it reads.
  assign w_unused = ^{instr_id[31:25], instr_id[14:12], r_wb};

  // NOTE: every state register uses non-blocking assignment so all stages shift together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_flush_cnt <= 3'd0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_id_entry;
      if (branch_taken) begin
        r_flush_cnt <= FLUSH_LOAD;
      end else if (r_flush_cnt != 3'd0) begin
        r_flush_cnt <= r_flush_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (w_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench: three hazard_sequencer configurations driven in lockstep, checked
// against hand-written vectors and a behavioural pipeline-occupancy model.
module tb_hazard_sequencer;

  localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_DEP   = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADDX0 = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] I_ADD5  = 32'h002082B3; // add  x5,x1,x2
  localparam logic [31:0] I_NOP   = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_LUI   = 32'h000283B7; // lui  x7 with rs1 field = 5
  localparam logic [31:0] I_SW5   = 32'h0050A023; // sw   x5,0(x1)

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] instr_id = '0;
  logic instr_valid = 1'b0;
  logic branch_taken = 1'b0;

  logic nop[3], pcwe[3], ifwe[3], st[3], fl[3];
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [2:0]  sc2, fc2;

  always #5 clk = ~clk;

  hazard_sequencer #(.FORWARDING(1'b1), .FLUSH_CYCLES(2), .COUNT_W(16)) dut_f1 (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .instr_valid(instr_valid),
    .branch_taken(branch_taken), .nop_o(nop[0]), .pc_write_en(pcwe[0]),
    .ifid_write_en(ifwe[0]), .stall_o(st[0]), .flush_o(fl[0]),
    .stall_count(sc0), .flush_count(fc0));

  hazard_sequencer #(.FORWARDING(1'b0), .FLUSH_CYCLES(3), .COUNT_W(16)) dut_f0 (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .instr_valid(instr_valid),
    .branch_taken(branch_taken), .nop_o(nop[1]), .pc_write_en(pcwe[1]),
    .ifid_write_en(ifwe[1]), .stall_o(st[1]), .flush_o(fl[1]),
    .stall_count(sc1), .flush_count(fc1));

  hazard_sequencer #(.FORWARDING(1'b1), .FLUSH_CYCLES(1), .COUNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .instr_valid(instr_valid),
    .branch_taken(branch_taken), .nop_o(nop[2]), .pc_write_en(pcwe[2]),
    .ifid_write_en(ifwe[2]), .stall_o(st[2]), .flush_o(fl[2]),
    .stall_count(sc2), .flush_count(fc2));

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_sc(input int k);
    case (k)
      0: return 32'(sc0);
      1: return 32'(sc1);
      default: return 32'(sc2);
    endcase
  endfunction

  function automatic logic [31:0] get_fc(input int k);
    case (k)
      0: return 32'(fc0);
      1: return 32'(fc1);
      default: return 32'(fc2);
    endcase
  endfunction

  // Reference model: the last two issued instructions (age 0 = EX, age 1 = MEM),
  // remaining flush cycles, and plain integer counters clipped at the counter maximum.
  typedef struct { bit wr; int rd; bit ld; } issued_t;
  issued_t hist[3][2];
  int m_flush_left[3], m_sc[3], m_fc[3];
  int p_fwd[3] = '{1, 0, 1};
  int p_fc[3]  = '{2, 3, 1};
  int p_max[3] = '{65535, 65535, 7};

  function automatic void m_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 2; a++) hist[k][a] = '{wr: 1'b0, rd: 0, ld: 1'b0};
      m_flush_left[k] = 0;
      m_sc[k] = 0;
      m_fc[k] = 0;
    end
  endfunction

  function automatic bit m_hit(input int k, input int r);
    if (r == 0) return 1'b0;
    if (p_fwd[k] != 0) return hist[k][0].wr && hist[k][0].rd == r && hist[k][0].ld;
    return (hist[k][0].wr && hist[k][0].rd == r) || (hist[k][1].wr && hist[k][1].rd == r);
  endfunction

  function automatic void m_eval(input int k, input logic [31:0] ins, input bit v, input bit br,
                                 output bit exp_st, output bit exp_fl);
    int op;
    bit u1, u2, hz;
    op = int'(ins[6:0]);
    u1 = !(op == 'h37 || op == 'h17 || op == 'h6F);
    u2 = (op == 'h33 || op == 'h23 || op == 'h63);
    hz = v && ((u1 && m_hit(k, int'(ins[19:15]))) || (u2 && m_hit(k, int'(ins[24:20]))));
    exp_fl = br || (m_flush_left[k] > 0);
    exp_st = hz && !exp_fl;
  endfunction

  function automatic void m_step(input int k, input logic [31:0] ins, input bit v, input bit br);
    bit s, f;
    int op, rd;
    m_eval(k, ins, v, br, s, f);
    op = int'(ins[6:0]);
    rd = int'(ins[11:7]);
    hist[k][1] = hist[k][0];
    hist[k][0] = '{wr: v && !s && !f && op != 'h23 && op != 'h63 && rd != 0,
                   rd: rd, ld: op == 'h03};
    m_flush_left[k] = br ? p_fc[k] - 1 : (m_flush_left[k] > 0 ? m_flush_left[k] - 1 : 0);
    if (s && m_sc[k] < p_max[k]) m_sc[k]++;
    if (f && m_fc[k] < p_max[k]) m_fc[k]++;
  endfunction

  task automatic apply(input logic [31:0] ins, input logic v, input logic br);
    bit s, f;
    instr_id = ins;
    instr_valid = v;
    branch_taken = br;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      m_eval(k, ins, v, br, s, f);
      check($sformatf("model stall[%0d]", k), 32'(st[k]), 32'(s));
      check($sformatf("model flush[%0d]", k), 32'(fl[k]), 32'(f));
      check($sformatf("model nop[%0d]", k), 32'(nop[k]), 32'(s | f));
      check($sformatf("model pc_we[%0d]", k), 32'(pcwe[k]), 32'(!s));
      check($sformatf("model ifid_we[%0d]", k), 32'(ifwe[k]), 32'(!s));
      check($sformatf("model stall_count[%0d]", k), get_sc(k), 32'(m_sc[k]));
      check($sformatf("model flush_count[%0d]", k), get_fc(k), 32'(m_fc[k]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 3; k++) m_step(k, instr_id, instr_valid, branch_taken);
    #1;
  endtask

  task automatic cycle(input logic [31:0] ins, input logic v, input logic br);
    apply(ins, v, br);
    advance();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s nop[%0d]", tag, k), 32'(nop[k]), 32'd1);
      check($sformatf("%s pc_we[%0d]", tag, k), 32'(pcwe[k]), 32'd0);
      check($sformatf("%s ifid_we[%0d]", tag, k), 32'(ifwe[k]), 32'd0);
      check($sformatf("%s stall[%0d]", tag, k), 32'(st[k]), 32'd0);
      check($sformatf("%s flush[%0d]", tag, k), 32'(fl[k]), 32'd0);
      check($sformatf("%s stall_count[%0d]", tag, k), get_sc(k), 32'd0);
      check($sformatf("%s flush_count[%0d]", tag, k), get_fc(k), 32'd0);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, checked immediately, released after one edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        v;
    logic        br;
    logic        e_st;
    logic        e_fl;
  } vec_t;

  vec_t vt[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = '{I_LW5,   1, 0, 0, 0};
    vt[1]  = '{I_DEP,   1, 0, 1, 0};
    vt[2]  = '{I_DEP,   1, 0, 0, 0};
    vt[3]  = '{I_LW0,   1, 0, 0, 0};
    vt[4]  = '{I_ADDX0, 1, 0, 0, 0};
    vt[5]  = '{I_LW5,   1, 0, 0, 0};
    vt[6]  = '{I_DEP,   1, 1, 0, 1};
    vt[7]  = '{I_DEP,   1, 0, 0, 1};
    vt[8]  = '{I_DEP,   1, 0, 0, 0};
    vt[9]  = '{I_DEP,   0, 0, 0, 0};
    vt[10] = '{I_LW5,   1, 0, 0, 0};
    vt[11] = '{I_DEP,   0, 0, 0, 0};
    vt[12] = '{I_LW5,   1, 0, 0, 0};
    vt[13] = '{I_LUI,   1, 0, 0, 0};
    vt[14] = '{I_LW5,   1, 0, 0, 0};
    vt[15] = '{I_SW5,   1, 0, 1, 0};
    vt[16] = '{I_SW5,   1, 0, 0, 0};

    m_reset();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(vt[i].ins, vt[i].v, vt[i].br);
      check($sformatf("vec%0d stall", i), 32'(st[0]), 32'(vt[i].e_st));
      check($sformatf("vec%0d flush", i), 32'(fl[0]), 32'(vt[i].e_fl));
      check($sformatf("vec%0d nop", i), 32'(nop[0]), 32'(vt[i].e_st | vt[i].e_fl));
      check($sformatf("vec%0d pc_we", i), 32'(pcwe[0]), 32'(!vt[i].e_st));
      advance();
      if (i == 2) check("load-use stall_count", 32'(sc0), 32'd1);
      if (i == 4) check("x0 load stall_count", 32'(sc0), 32'd1);
    end
    check("table stall_count", 32'(sc0), 32'd2);
    check("table flush_count", 32'(fc0), 32'd2);

    // No forwarding: back-to-back dependence stalls twice, one gap stalls once.
    cycle(I_NOP, 1, 0);
    apply(I_ADD5, 1, 0); check("nf add5 stall", 32'(st[1]), 32'd0); advance();
    apply(I_DEP, 1, 0);  check("nf dep stall1", 32'(st[1]), 32'd1);
    check("nf dep fwd stall", 32'(st[0]), 32'd0); advance();
    apply(I_DEP, 1, 0);  check("nf dep stall2", 32'(st[1]), 32'd1); advance();
    apply(I_DEP, 1, 0);  check("nf dep release", 32'(st[1]), 32'd0); advance();
    apply(I_ADD5, 1, 0); check("nf gap add5", 32'(st[1]), 32'd0); advance();
    cycle(I_NOP, 1, 0);
    apply(I_DEP, 1, 0);  check("nf gap stall", 32'(st[1]), 32'd1); advance();
    apply(I_DEP, 1, 0);  check("nf gap release", 32'(st[1]), 32'd0); advance();

    // Reset while flush_cnt is 1, then a single branch pulse from zeroed counters.
    cycle(I_NOP, 1, 1);
    apply(I_NOP, 1, 0);
    check("midflush flush", 32'(fl[0]), 32'd1);
    async_reset("midflush");
    apply(I_NOP, 1, 0);  check("post reset flush", 32'(fl[0]), 32'd0); advance();
    apply(I_NOP, 1, 1);
    check("br c0 flush", 32'(fl[0]), 32'd1);
    check("br c0 nop", 32'(nop[0]), 32'd1);
    check("br c0 pc_we", 32'(pcwe[0]), 32'd1);
    advance();
    apply(I_NOP, 1, 0);
    check("br c1 flush", 32'(fl[0]), 32'd1);
    check("br c1 pc_we", 32'(pcwe[0]), 32'd1);
    advance();
    apply(I_NOP, 1, 0);
    check("br c2 flush", 32'(fl[0]), 32'd0);
    check("br flush_count", 32'(fc0), 32'd2);
    advance();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [6:0] ops[9];
      ops = '{7'h03, 7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13, 7'h67};
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 8)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      apply(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 99) == 0) async_reset("random reset");
      else advance();
    end

    for (int n = 0; n < 10; n++) cycle(I_NOP, 1, 1);
    check("saturated flush_count", 32'(fc2), 32'd7);
    cycle(I_NOP, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
